// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned MUL_LAT  = 8;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mul.sv
// Shared 8-cycle shift-add unsigned multiplier with start/busy handshake.
module mul
    import mul_arb_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic [2*W-1:0]   p
);

    localparam int unsigned CW = $clog2(MUL_LAT + 1);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    // One partial product per cycle; busy drops after the last step so p is final.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            p      <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            p      <= '0;
            mcand  <= (2*W)'(a);
            mplier <= b;
            cnt    <= CW'(MUL_LAT);
        end else if (busy) begin
            if (mplier[0]) begin
                p <= p + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester above ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win_c,
    output logic [IW-1:0]   idx_c,
    output logic            any_c
);

    always_comb begin
        logic [IW-1:0] jj;
        win_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        jj    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            jj = IW'((32'(ptr) + k) % NREQ);
            if (!any_c && req[jj]) begin
                any_c     = 1'b1;
                win_c[jj] = 1'b1;
                idx_c     = jj;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ requesters.
// MUL_ARBITER_STATS_EN adds a saturating 16-bit completed-operation counter (op_cnt).
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [2*W-1:0]    y,
    output logic              busy
`ifdef MUL_ARBITER_STATS_EN
    ,
    output logic [15:0]       op_cnt
`endif
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            start_q, start_d;
    logic            first_q, first_d;
    logic [NREQ-1:0] gnt_d, done_d;
    logic [2*W-1:0]  y_d;
    logic            busy_d;
`ifdef MUL_ARBITER_STATS_EN
    logic [15:0]     op_cnt_d;
`endif

    logic [NREQ-1:0] win_c;
    logic [IW-1:0]   sel_idx_c;
    logic            any_c;
    logic            mul_busy;
    logic [2*W-1:0]  mul_p;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win_c (win_c),
        .idx_c (sel_idx_c),
        .any_c (any_c)
    );

    mul #(
        .W (W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .a     (a_q),
        .b     (b_q),
        .busy  (mul_busy),
        .p     (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            first_q <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            y       <= '0;
            busy    <= 1'b0;
`ifdef MUL_ARBITER_STATS_EN
            op_cnt  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            first_q <= first_d;
            gnt     <= gnt_d;
            done    <= done_d;
            y       <= y_d;
            busy    <= busy_d;
`ifdef MUL_ARBITER_STATS_EN
            op_cnt  <= op_cnt_d;
`endif
        end
    end

    // Next state; gnt/start/done are computed one cycle early so they register into their state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        start_d = 1'b0;
        first_d = 1'b0;
        gnt_d   = '0;
        done_d  = '0;
        y_d     = y;

        unique case (state_q)
            IDLE: begin
                if (any_c) begin
                    a_d     = a_in[32'(sel_idx_c)*W +: W];
                    b_d     = b_in[32'(sel_idx_c)*W +: W];
                    idx_d   = sel_idx_c;
                    ptr_d   = sel_idx_c;
                    gnt_d   = win_c;
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                first_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Multiplier busy lags start by a cycle, so the first WAIT cycle is skipped.
                if (!first_q && !mul_busy) begin
                    y_d           = mul_p;
                    done_d[idx_q] = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef MUL_ARBITER_STATS_EN
    always_comb begin
        op_cnt_d = op_cnt;
        if (state_q == DONE && op_cnt != 16'hFFFF) begin
            op_cnt_d = op_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: latency, ordering, operands, reset abort, drop.
module tb_mul_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    typedef struct {
        int          idx;
        logic [15:0] y;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [2*W-1:0]    y;
    logic              busy;
`ifdef MUL_ARBITER_STATS_EN
    logic [15:0]       op_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;
    exp_t sb[$];
    int   gnt_idx[$];
    int   gnt_cyc[$];

    mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .done   (done),
        .y      (y),
        .busy   (busy)
`ifdef MUL_ARBITER_STATS_EN
        ,
        .op_cnt (op_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (gnt != 0 || done != 0) begin
                checks++;
                if (!$onehot0(gnt) || !$onehot0(done) || (gnt != 0 && done != 0)) begin
                    failures++;
                    $display("FAIL onehot_excl gnt=%b done=%b", gnt, done);
                end
            end
            if (done != 0) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done done=%b y=%0d", done, y);
                end else begin
                    exp_t e;
                    logic [NREQ-1:0] ed;
                    e = sb.pop_front();
                    ed = '0;
                    ed[e.idx] = 1'b1;
                    if (done !== ed || y !== e.y) begin
                        failures++;
                        $display("FAIL sb_done got done=%b y=%0d want done=%b y=%0d", done, y, ed, e.y);
                    end
                end
            end
            if (gnt != 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) gnt_idx.push_back(i);
                end
                gnt_cyc.push_back(ncyc);
            end
        end
    end

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
    endtask

    // Drives one lone request, scrambles its operands after grant; returns latencies (-1 on timeout).
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          output int g_lat, output int d_lat);
        exp_t e;
        @(negedge clk);
        set_ops(idx, a, b);
        req[idx] = 1'b1;
        e.idx = idx;
        e.y   = 16'(a) * 16'(b);
        sb.push_back(e);
        g_lat = -1;
        d_lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (g_lat < 0 && gnt != 0) begin
                g_lat = k;
                req[idx] = 1'b0;
                set_ops(idx, ~a, ~b);
            end
            if (done != 0) begin
                d_lat = k;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (gnt !== 4'b0)   begin failures++; $display("FAIL reset_gnt got=%b want=0", gnt); end
        if (done !== 4'b0)  begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        if (y !== 16'd0)    begin failures++; $display("FAIL reset_y got=%0d want=0", y); end
        if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int g, d;
        run_op(0, 8'd12, 8'd13, g, d);
        checks += 4;
        if (g != 1)         begin failures++; $display("FAIL single_gnt_lat got=%0d want=1", g); end
        if (d != 11)        begin failures++; $display("FAIL single_done_lat got=%0d want=11", d); end
        if (y !== 16'd156)  begin failures++; $display("FAIL single_y got=%0d want=156", y); end
        if (busy !== 1'b1)  begin failures++; $display("FAIL single_busy_done got=%b want=1", busy); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)  begin failures++; $display("FAIL single_busy_idle got=%b want=0", busy); end
        if (y !== 16'd156)  begin failures++; $display("FAIL single_y_hold got=%0d want=156", y); end
    endtask

    task automatic test_boundary();
        int g, d;
        run_op(3, 8'd255, 8'd255, g, d);
        checks += 2;
        if (d != 11)          begin failures++; $display("FAIL max_lat got=%0d want=11", d); end
        if (y !== 16'd65025)  begin failures++; $display("FAIL max_y got=%0d want=65025", y); end
        run_op(2, 8'd0, 8'd200, g, d);
        checks++;
        if (y !== 16'd0)      begin failures++; $display("FAIL zero_y got=%0d want=0", y); end
        run_op(1, 8'd7, 8'd9, g, d);
        checks++;
        if (y !== 16'd63)     begin failures++; $display("FAIL late_change_y got=%0d want=63", y); end
    endtask

    task automatic test_contention();
        int lo;
        int want[5] = '{0, 1, 2, 3, 0};
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i + 3), 8'(i * 10 + 5));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e.idx = want[k];
            e.y   = 16'(want[k] + 3) * 16'(want[k] * 10 + 5);
            sb.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        lo = gnt_idx.size();
        for (int k = 0; k < 100 && gnt_idx.size() < lo + 5; k++) @(negedge clk);
        req = '0;
        checks++;
        if (gnt_idx.size() < lo + 5) begin
            failures++;
            $display("FAIL contention_timeout grants=%0d want=5", gnt_idx.size() - lo);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (gnt_idx[lo + k] != want[k]) begin
                    failures++;
                    $display("FAIL contention_order n=%0d got=%0d want=%0d", k, gnt_idx[lo + k], want[k]);
                end
            end
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (gnt_cyc[lo + k] - gnt_cyc[lo + k - 1] != 12) begin
                    failures++;
                    $display("FAIL contention_gap n=%0d got=%0d want=12", k,
                             gnt_cyc[lo + k] - gnt_cyc[lo + k - 1]);
                end
            end
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_abort();
        exp_t e;
        int   g;
        @(negedge clk);
        set_ops(2, 8'd9, 8'd9);
        req[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (gnt !== 4'b0100) begin failures++; $display("FAIL abort_gnt got=%b want=0100", gnt); end
                req = '0;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (y !== 16'd0)   begin failures++; $display("FAIL abort_y got=%0d want=0", y); end
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (done !== 4'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
        repeat (15) @(negedge clk);
        set_ops(0, 8'd21, 8'd3);
        set_ops(3, 8'd4, 8'd4);
        e.idx = 0;
        e.y   = 16'd63;
        sb.push_back(e);
        req = 4'b1001;
        g = 0;
        for (int k = 1; k <= 20 && g == 0; k++) begin
            @(negedge clk);
            if (gnt != 0) g = 1;
        end
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL abort_restart got=%b want=0001", gnt); end
        req = '0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_drop();
        exp_t e;
        int   ngnt;
        int   seen;
        set_ops(1, 8'd11, 8'd11);
        set_ops(2, 8'd5, 8'd5);
        e.idx = 1;
        e.y   = 16'd121;
        sb.push_back(e);
        req = 4'b0110;
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1;
        end
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL drop_first got=%b want=0010", gnt); end
        req = '0;
        ngnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (gnt != 0) ngnt++;
        end
        checks += 2;
        if (ngnt != 0)     begin failures++; $display("FAIL drop_regrant got=%0d want=0", ngnt); end
        if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b want=0", busy); end
        set_ops(0, 8'd2, 8'd2);
        set_ops(3, 8'd6, 8'd7);
        e.idx = 3;
        e.y   = 16'd42;
        sb.push_back(e);
        req = 4'b1001;
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1;
        end
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL drop_order got=%b want=1000", gnt); end
        req = '0;
        repeat (14) @(negedge clk);
    endtask

`ifdef MUL_ARBITER_STATS_EN
    task automatic test_stats();
        int g, d;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 8'd1, 8'd2, g, d);
        run_op(1, 8'd3, 8'd4, g, d);
        run_op(2, 8'd5, 8'd6, g, d);
        @(negedge clk);
        checks++;
        if (op_cnt !== 16'd3) begin failures++; $display("FAIL stats_cnt got=%0d want=3", op_cnt); end
        force dut.op_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.op_cnt;
        run_op(3, 8'd7, 8'd8, g, d);
        @(negedge clk);
        checks++;
        if (op_cnt !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h want=ffff", op_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_contention();
        test_abort();
        test_drop();
`ifdef MUL_ARBITER_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
